// File: rtl/adc_seq_array_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_array_if
// Description : Command/status bundle between the top-level command FSM, the
//               adc_seq_array sequencer and the per-chip front-ends.
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_seq_array_if #(
  parameter int CHIP_NUM = 4,
  parameter int TEMP_W   = 16
);
  logic                       start;
  logic [1:0]                 cmd;
  logic [CHIP_NUM-1:0]        chip_en;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [CHIP_NUM-1:0]        chip_fs;
  logic [1:0]                 chip_cmd;
  logic [CHIP_NUM-1:0]        chip_fd;
  logic [CHIP_NUM*TEMP_W-1:0] chip_temp;
  logic [2*CHIP_NUM-1:0]      chip_type;
  logic [TEMP_W-1:0]          temp_avg;
  logic [2*CHIP_NUM-1:0]      type_out;
  logic [CHIP_NUM-1:0]        tout_stat;

  modport master (
    output start, cmd, chip_en, chip_fd, chip_temp, chip_type,
    input  busy, done, err, chip_fs, chip_cmd, temp_avg, type_out, tout_stat
  );

  modport slave (
    input  start, cmd, chip_en, chip_fd, chip_temp, chip_type,
    output busy, done, err, chip_fs, chip_cmd, temp_avg, type_out, tout_stat
  );
endinterface
`default_nettype wire

// File: rtl/adc_seq_array.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_array
// Description : Issues one command to a masked set of front-end chips, waits
//               for their done flags with timeout, and averages temperatures.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_array #(
  parameter int CHIP_NUM = 4,
  parameter int TEMP_W   = 16,
  parameter int TOUT     = 50000
) (
  input wire clk,
  input wire rst,
  adc_seq_array_if.slave bus
);

  localparam int ACC_W = TEMP_W + $clog2(CHIP_NUM);
  localparam int CNT_W = $clog2(CHIP_NUM + 1);
  localparam int IDX_W = (CHIP_NUM > 1) ? $clog2(CHIP_NUM) : 1;
  localparam int TMR_W = $clog2(TOUT);
  localparam int DIV_W = $clog2(ACC_W);

  localparam logic [1:0] CMD_TYPE = 2'd1;
  localparam logic [1:0] CMD_CONV = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ACC   = 3'd3;
  localparam logic [2:0] ST_DIV   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [1:0]            cmd_q,   cmd_d;
  logic [CHIP_NUM-1:0]   en_q,    en_d;
  logic [CHIP_NUM-1:0]   seen_q,  seen_d;
  logic [CHIP_NUM-1:0]   tout_q,  tout_d;
  logic                  err_q,   err_d;
  logic [TMR_W-1:0]      tmr_q,   tmr_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [DIV_W-1:0]      div_q,   div_d;
  logic [ACC_W-1:0]      acc_q,   acc_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic [CNT_W-1:0]      rem_q,   rem_d;
  logic [TEMP_W-1:0]     avg_q,   avg_d;
  logic [2*CHIP_NUM-1:0] type_q,  type_d;

  logic [TEMP_W-1:0]     temp_arr [CHIP_NUM];
  logic [2*CHIP_NUM-1:0] type_mask;
  logic                  all_seen;
  logic [CNT_W:0]        rem_sh;
  logic                  rem_ge;
  logic [CNT_W-1:0]      rem_sub;
  logic [ACC_W-1:0]      quo_sh;

  generate
    for (genvar i = 0; i < CHIP_NUM; i++) begin : g_chip
      assign temp_arr[i]          = bus.chip_temp[i*TEMP_W +: TEMP_W];
      assign type_mask[2*i +: 2]  = en_q[i] ? bus.chip_type[2*i +: 2] : 2'b00;
    end
  endgenerate

  assign all_seen = &(seen_q | ~en_q);

  // Restoring divide: the accumulator doubles as the dividend/quotient shift
  // register, so after ACC_W steps it holds the quotient.
  assign rem_sh  = {rem_q, acc_q[ACC_W-1]};
  assign rem_ge  = (rem_sh >= {1'b0, cnt_q});
  assign rem_sub = rem_sh[CNT_W-1:0] - cnt_q;
  assign quo_sh  = {acc_q[ACC_W-2:0], rem_ge};

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    en_d    = en_q;
    seen_d  = seen_q;
    tout_d  = tout_q;
    err_d   = err_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    div_d   = div_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    avg_d   = avg_q;
    type_d  = type_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          cmd_d   = bus.cmd;
          en_d    = bus.chip_en;
          seen_d  = '0;
          tout_d  = '0;
          err_d   = 1'b0;
        end
      end

      ST_ISSUE: begin
        tmr_d   = '0;
        state_d = (en_q == '0) ? ST_DONE : ST_WAIT;
      end

      ST_WAIT: begin
        seen_d = seen_q | (bus.chip_fd & en_q);
        tmr_d  = tmr_q + TMR_W'(1);
        // Completion is checked first so it wins over a coincident timeout.
        if (all_seen) begin
          if (cmd_q == CMD_CONV) begin
            state_d = ST_ACC;
            idx_d   = '0;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            if (cmd_q == CMD_TYPE) begin
              type_d = type_mask;
            end
            state_d = ST_DONE;
          end
        end else if (tmr_q == TMR_W'(TOUT - 1)) begin
          tout_d  = en_q & ~seen_q;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_ACC: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(temp_arr[idx_q]);
          cnt_d = cnt_q + CNT_W'(1);
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(CHIP_NUM - 1)) begin
          state_d = ST_DIV;
          div_d   = '0;
          rem_d   = '0;
        end
      end

      ST_DIV: begin
        rem_d = rem_ge ? rem_sub : rem_sh[CNT_W-1:0];
        acc_d = quo_sh;
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_W'(ACC_W - 1)) begin
          avg_d   = quo_sh[TEMP_W-1:0];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      en_q    <= '0;
      seen_q  <= '0;
      tout_q  <= '0;
      err_q   <= 1'b0;
      tmr_q   <= '0;
      idx_q   <= '0;
      div_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      avg_q   <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      en_q    <= en_d;
      seen_q  <= seen_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      avg_q   <= avg_d;
      type_q  <= type_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.chip_fs   = (state_q == ST_WAIT) ? en_q : '0;
  assign bus.chip_cmd  = cmd_q;
  assign bus.temp_avg  = avg_q;
  assign bus.type_out  = type_q;
  assign bus.tout_stat = tout_q;

endmodule
`default_nettype wire
